decoder_scan_sequencer: RTL and testbench
=========================================

# decoder_scan_sequencer

Upstream control stage for the 3-to-8 decoder: it generates the decoder's `en` and `a[2:0]` inputs so the one-hot outputs step through a programmable set of channels. Each channel is held for a programmable number of clock cycles. Enabled channels are taken from an 8-bit mask in ascending index order, either once (single sweep) or repeatedly (continuous). All outputs are registered so they drive the decoder's combinational inputs glitch-free.

## Interface
- `DW`, default 8: width of the dwell-count input and the internal dwell counter.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`, input, 1: request a sweep; sampled only in IDLE.
- `stop`, input, 1: abort the sweep in progress.
- `mode`, input, 1: 0 = single sweep, 1 = continuous; latched at accepted `start`.
- `chan_mask`, input, 8: bit i = 1 selects channel i; latched at accepted `start`.
- `dwell`, input, DW: cycles per channel; latched at accepted `start`; 0 is treated as 1.
- `en`, output, 1: decoder enable, registered.
- `a`, output, 3: decoder select, registered; forced to 0 whenever `en` = 0.
- `busy`, output, 1: high while in SCAN; equal to `en`.
- `done`, output, 1: one-cycle pulse when a single sweep completes normally.

## Operation
- States: IDLE and SCAN.
- IDLE → SCAN requires all of the following on the same edge: `start` = 1, `stop` = 0, `chan_mask` ≠ 0.
  - Latch `mask_q`, `mode_q`, and `dwell_q` = max(`dwell`, 1).
  - Load `a` = lowest set bit of `chan_mask`.
  - Set `en` = 1 and dwell counter = `dwell_q` − 1.
- `start` with `chan_mask` = 0 is ignored: no state change, no `done`.
- `start` in SCAN is ignored. Input changes during SCAN have no effect because only the latched values are used.
- In SCAN, each edge with counter ≠ 0 decrements the counter and holds `a`.
- When counter = 0, find the next channel: the lowest set bit of `mask_q` strictly above `a`.
  - If one exists, load it into `a` and reload the counter with `dwell_q` − 1.
  - If none exists and `mode_q` = 1, wrap to the lowest set bit of `mask_q` and reload.
  - If none exists and `mode_q` = 0, go to IDLE: `en` = 0, `a` = 0, `done` = 1 for exactly one cycle.
- If `mask_q` has a single bit set in continuous mode, `a` stays constant, `en` stays high, and the counter reloads every `dwell_q` cycles.
- `stop` = 1 in SCAN takes priority over dwell expiry. On that edge: go to IDLE, `en` = 0, `a` = 0, `done` = 0.
- `stop` = 1 in IDLE has no effect. If `start` and `stop` are both 1 in IDLE, `stop` wins and the start is not accepted.
- A new `start` can be accepted in the same cycle `done` is high, because the block is already in IDLE.

## Timing
- Reset values: state = IDLE, `en` = 0, `a` = 0, `busy` = 0, `done` = 0, and all latched registers = 0.
- Reset applies on any edge with `rst_n` = 0, including mid-sweep, and overrides `start` and `stop`.
- Start latency: when `start` is accepted at edge k, `en` = 1 and `a` is valid from edge k onward. They are visible in the cycle following the start cycle.
- Each selected channel is presented for exactly `dwell_q` consecutive cycles.
- Channel-to-channel transitions have no gap cycle: `en` stays high and `a` changes on a single edge.
- Single-sweep length with N set mask bits is N × `dwell_q` cycles of `en` = 1. `done` rises on the edge where `en` falls.
- Stop latency is one edge: `en` is low in the cycle after `stop` is sampled high.
- The dwell counter is DW bits wide; the maximum dwell is 2^DW − 1.

## Structure
- Package `decoder_pkg` holds:
  - `SEL_W` = 3 and `NUM_CH` = 8;
  - `typedef enum logic {IDLE, SCAN} scan_state_t`;
  - `typedef logic [NUM_CH-1:0] chan_mask_t`.
- Sub-module `scan_next_chan` is purely combinational.
  - Inputs: `mask_q`, current `a`, `mode_q`.
  - Outputs: `next_a`, `next_valid`, and `first_a` (lowest set bit, used for start).
- The dwell counter and the state machine stay in the top-level module.

## Test plan
- Reset mid-sweep: with mask 8'hFF, `dwell` = 3, mode 1, assert `rst_n` = 0 for one edge → next cycle `en` = 0, `a` = 0, `busy` = 0, `done` = 0. A later `start` begins again at `a` = 0.
- Single sweep: mask 8'b1010_0100, `dwell` = 2, mode 0 → `a` sequence is 2, 2, 5, 5, 7, 7 with `en` = 1 throughout. Then `en` = 0, `a` = 0, and `done` is high for one cycle.
- Continuous wrap with zero dwell: mask 8'b1000_0001, `dwell` = 0, mode 1 → `a` sequence is 0, 7, 0, 7, … with one cycle per channel and `en` never dropping. Inputs changed mid-sweep cause no effect.
- Stop mid-dwell: mask 8'h10, `dwell` = 5, `stop` pulsed on the 3rd SCAN cycle → the next cycle has `en` = 0, `a` = 0, `done` = 0. Separately, `start` and `stop` both high in IDLE → remains IDLE.
- Ignored starts: `start` with mask 0 → stays IDLE, no `done`. A second `start` while busy → sequence unchanged. `start` in the `done` cycle → `en` = 1 on the next cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths and types for the decoder scan sequencer.
//   SEL_W        - width of the decoder select bus
//   NUM_CH       - number of decoder channels
//   scan_state_t - sequencer FSM states
//   chan_mask_t  - one bit per decoder channel
package decoder_pkg;
    localparam int SEL_W  = 3;
    localparam int NUM_CH = 8;
    typedef enum logic {IDLE, SCAN} scan_state_t;
    typedef logic [NUM_CH-1:0] chan_mask_t;
endpackage

// File: rtl/scan_next_chan.sv
// scan_next_chan: combinational next-channel search over a channel mask.
//   mask_i       - channels taking part in the sweep
//   a_i          - channel currently presented
//   mode_i       - 1 = wrap to the lowest channel after the highest
//   next_a_o     - channel to present after a_i
//   next_valid_o - a next channel exists (otherwise the sweep ends)
//   first_a_o    - lowest set bit of mask_i
module scan_next_chan
    import decoder_pkg::*;
(
    input  chan_mask_t       mask_i,
    input  logic [SEL_W-1:0] a_i,
    input  logic             mode_i,
    output logic [SEL_W-1:0] next_a_o,
    output logic             next_valid_o,
    output logic [SEL_W-1:0] first_a_o
);
    logic [SEL_W-1:0] up_a;
    logic             up_found;

    // Scanning downward leaves the lowest qualifying index in each result.
    always_comb begin
        up_a      = '0;
        up_found  = 1'b0;
        first_a_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) first_a_o = SEL_W'(i);
            if (mask_i[i] && SEL_W'(i) > a_i) begin
                up_a     = SEL_W'(i);
                up_found = 1'b1;
            end
        end
        next_a_o     = up_found ? up_a : first_a_o;
        next_valid_o = up_found | (mode_i & |mask_i);
    end
endmodule

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: drives a 3-to-8 decoder's en/a through masked channels with a per-channel dwell.
//   clk_i       - clock, rising edge
//   rst_ni      - synchronous active-low reset
//   start_i     - request a sweep (accepted only in IDLE, mask non-zero, no stop)
//   stop_i      - abort the sweep in progress
//   mode_i      - 0 = single sweep, 1 = continuous (latched at start)
//   chan_mask_i - channels to visit (latched at start)
//   dwell_i     - cycles per channel, 0 treated as 1 (latched at start)
//   en_o        - registered decoder enable
//   a_o         - registered decoder select, 0 when en_o is low
//   busy_o      - sweep in progress, equal to en_o
//   done_o      - one-cycle pulse when a single sweep completes
module decoder_scan_sequencer
    import decoder_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  chan_mask_t       chan_mask_i,
    input  logic [DW-1:0]    dwell_i,
    output logic             en_o,
    output logic [SEL_W-1:0] a_o,
    output logic             busy_o,
    output logic             done_o
);
    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] a_q, a_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    chan_mask_t       mask_q, mask_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    chan_mask_t       search_mask;
    logic [SEL_W-1:0] next_a, first_a;
    logic             next_valid;
    logic [DW-1:0]    dwell_eff;

    // In IDLE the searcher looks at the live mask to find the start channel;
    // during SCAN it only ever sees the latched mask.
    assign search_mask = (state_q == IDLE) ? chan_mask_i : mask_q;
    assign dwell_eff   = (dwell_i == '0) ? DW'(1) : dwell_i;

    scan_next_chan u_next (
        .mask_i      (search_mask),
        .a_i         (a_q),
        .mode_i      (mode_q),
        .next_a_o    (next_a),
        .next_valid_o(next_valid),
        .first_a_o   (first_a)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start_i && !stop_i && |chan_mask_i) begin
                state_d = SCAN;
                mask_d  = chan_mask_i;
                mode_d  = mode_i;
                dwell_d = dwell_eff;
                a_d     = first_a;
                cnt_d   = dwell_eff - 1'b1;
            end
        end else if (stop_i) begin
            state_d = IDLE;
            a_d     = '0;
            cnt_d   = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (next_valid) begin
            a_d   = next_a;
            cnt_d = dwell_q - 1'b1;
        end else begin
            state_d = IDLE;
            a_d     = '0;
            done_d  = 1'b1;
        end
    end

    assign en_o   = (state_q == SCAN);
    assign busy_o = en_o;
    assign a_o    = a_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: random and directed checks against a queue-based schedule model.
module tb_decoder_scan_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] mask = '0;
    logic [7:0] dwell = '0;
    logic       en, busy, done;
    logic [2:0] a;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         m_busy = 0;
    bit         m_done = 0;
    bit         m_mode = 0;
    logic [7:0] m_mask = '0;
    int         m_dwell = 1;
    int         sched[$];
    int         seen[6];
    int         exp_seq[6] = '{2, 2, 5, 5, 7, 7};

    always #5 clk = ~clk;

    decoder_scan_sequencer dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .stop_i     (stop),
        .mode_i     (mode),
        .chan_mask_i(mask),
        .dwell_i    (dwell),
        .en_o       (en),
        .a_o        (a),
        .busy_o     (busy),
        .done_o     (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // One sweep expanded into the per-cycle channel list.
    function automatic void refill();
        for (int ch = 0; ch < 8; ch++)
            if (m_mask[ch])
                for (int d = 0; d < m_dwell; d++) sched.push_back(ch);
    endfunction

    task automatic tick();
        @(posedge clk);
        m_done = 0;
        if (!rst_n) begin
            m_busy = 0;
            sched.delete();
        end else if (m_busy) begin
            if (stop) begin
                m_busy = 0;
                sched.delete();
            end else begin
                void'(sched.pop_front());
                if (sched.size() == 0) begin
                    if (m_mode) refill();
                    else begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
        end else if (start && !stop && mask != 0) begin
            m_mask  = mask;
            m_mode  = mode;
            m_dwell = (dwell == 0) ? 1 : int'(dwell);
            refill();
            m_busy = 1;
        end
        #1;
        check("en", int'(en), int'(m_busy));
        check("busy", int'(busy), int'(m_busy));
        check("a", int'(a), m_busy ? sched[0] : 0);
        check("done", int'(done), int'(m_done));
    endtask

    task automatic go(input logic [7:0] m, input logic [7:0] d, input logic md);
        mask = m; dwell = d; mode = md; start = 1; stop = 0;
        tick();
        start = 0;
    endtask

    initial begin
        tick(); tick();
        check("rst_en", int'(en), 0);
        rst_n = 1;
        // reset mid-sweep
        go(8'hFF, 8'd3, 1'b1);
        repeat (5) tick();
        rst_n = 0; tick();
        check("rst_mid_en", int'(en), 0);
        check("rst_mid_a", int'(a), 0);
        rst_n = 1; tick();
        go(8'hFF, 8'd3, 1'b1);
        check("restart_a0", int'(a), 0);
        stop = 1; tick(); stop = 0;
        // single sweep
        go(8'b1010_0100, 8'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            seen[i] = int'(a);
            check("sweep_en", int'(en), 1);
            if (i < 5) tick();
        end
        for (int i = 0; i < 6; i++) check("sweep_seq", seen[i], exp_seq[i]);
        tick();
        check("sweep_done", int'(done), 1);
        check("sweep_end_a", int'(a), 0);
        tick();
        check("done_pulse", int'(done), 0);
        // continuous wrap, zero dwell, inputs disturbed mid-sweep
        go(8'b1000_0001, 8'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("wrap_a", int'(a), (i % 2) * 7);
            mask = 8'($urandom); dwell = 8'($urandom); mode = 1'($urandom); start = 1;
            tick();
            start = 0;
        end
        stop = 1; tick(); stop = 0;
        // stop on the third SCAN cycle
        go(8'h10, 8'd5, 1'b0);
        tick(); tick();
        stop = 1; tick();
        check("stop_en", int'(en), 0);
        check("stop_done", int'(done), 0);
        start = 1; mask = 8'h10; tick();
        check("start_stop_idle", int'(en), 0);
        start = 0; stop = 0;
        // ignored starts
        go(8'h00, 8'd1, 1'b0);
        check("mask0_en", int'(en), 0);
        go(8'h06, 8'd2, 1'b0);
        start = 1; mask = 8'h80; tick(); tick(); tick(); start = 0;
        tick();
        go(8'h01, 8'd1, 1'b0);
        tick();
        check("done_cycle", int'(done), 1);
        start = 1; mask = 8'h08; tick(); start = 0;
        check("done_restart_en", int'(en), 1);
        check("done_restart_a", int'(a), 3);
        tick();
        // maximum dwell
        go(8'h41, 8'd255, 1'b0);
        repeat (515) tick();
        // random traffic
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            mode  = 1'($urandom);
            mask  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            dwell = 8'($urandom_range(0, 3));
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
